// File: rtl/code_mem_pkg.sv
// -----------------------------------------------------------------------------
// code_mem_pkg
//
// Shared definitions for the code-memory loader and its post-boot readers:
//   - on-chip code RAM geometry and the derived byte-address width
//   - the access-size encoding used by the MCU-side read front-end
//   - the state encoding of the multi-byte flash reader FSM
//   - a helper mapping an access size to the index of its last byte lane
// -----------------------------------------------------------------------------
package code_mem_pkg;

   localparam int ON_CHIP_CODE_RAM_SIZE_IN_BYTES = 32768;
   localparam int CODE_MEM_ADDR_WIDTH            = $clog2(ON_CHIP_CODE_RAM_SIZE_IN_BYTES);

   // Access size as encoded on req_size.
   typedef enum logic [1:0] {
      FLASH_RD_SIZE_1       = 2'd0,
      FLASH_RD_SIZE_2       = 2'd1,
      FLASH_RD_SIZE_4       = 2'd2,
      FLASH_RD_SIZE_ILLEGAL = 2'd3
   } flash_rd_size_e;

   // Flash reader FSM states.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READY = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4,
      S_FAULT = 3'd5
   } reader_state_e;

   // Index of the final byte lane for a legal size (2^size - 1).
   function automatic logic [1:0] last_byte_index(input flash_rd_size_e size);
      logic [1:0] idx;
      case (size)
         FLASH_RD_SIZE_1: idx = 2'd0;
         FLASH_RD_SIZE_2: idx = 2'd1;
         FLASH_RD_SIZE_4: idx = 2'd3;
         default:         idx = 2'd0;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/code_mem_flash_reader.sv
// -----------------------------------------------------------------------------
// code_mem_flash_reader
//
// Multi-byte read front-end for the code-memory loader's single-byte flash
// port. Accepts 1/2/4-byte little-endian requests from the MCU side over a
// ready/valid handshake, issues one byte read at a time to the loader,
// assembles the returned bytes and produces a single response strobe.
//
// Parameters
//   ADDR_WIDTH       byte-address width of the code RAM
//   TIMEOUT_CYCLES   wait cycles allowed per byte before a fault (1..65535)
//
// Ports
//   clk                in   clock, all logic on its rising edge
//   sync_reset         in   synchronous active-high reset
//   loader_done        in   loader power-on copy finished; byte port usable
//   req_valid          in   request present
//   req_ready          out  request accepted when high with req_valid
//   req_page           in   flash page index
//   req_addr           in   start byte address
//   req_size           in   0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal
//   rsp_valid          out  one-cycle response strobe
//   rsp_data           out  assembled data, byte i in [8i+7:8i], unused lanes 0
//   rsp_error          out  qualifies rsp_valid: illegal size or timeout
//   flash_read_enable  out  one-cycle byte-read pulse to the loader
//   page_index         out  page to the loader
//   flash_byte_addr    out  byte address to the loader
//   flash_read_en_out  in   loader byte-valid strobe
//   flash_byte_out     in   loader byte data
//
// All outputs are registered. A timeout leaves the block in S_FAULT until
// sync_reset, since the loader may still complete the abandoned read.
// -----------------------------------------------------------------------------
module code_mem_flash_reader
   import code_mem_pkg::*;
#(
   parameter int ADDR_WIDTH     = CODE_MEM_ADDR_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  sync_reset,
   input  logic                  loader_done,

   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_page,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [1:0]            req_size,

   output logic                  rsp_valid,
   output logic [31:0]           rsp_data,
   output logic                  rsp_error,

   output logic                  flash_read_enable,
   output logic [3:0]            page_index,
   output logic [ADDR_WIDTH-1:0] flash_byte_addr,
   input  logic                  flash_read_en_out,
   input  logic [7:0]            flash_byte_out
);

   // Terminal count of the per-byte wait counter.
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   reader_state_e         state;
   flash_rd_size_e        lat_size;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [1:0]            byte_idx;
   logic [31:0]           acc;
   logic [15:0]           to_cnt;
   logic                  advance;    // next byte's address/pulse due this cycle
   logic                  timed_out;  // response in flight is a timeout fault

   // Place one byte into lane idx of the accumulator.
   function automatic logic [31:0] lane_merge(input logic [31:0] acc_in,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
      logic [31:0] r;
      r = acc_in;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

   logic [31:0] merged;
   assign merged = lane_merge(acc, byte_idx, flash_byte_out);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state             <= S_IDLE;
         req_ready         <= 1'b0;
         rsp_valid         <= 1'b0;
         rsp_data          <= 32'd0;
         rsp_error         <= 1'b0;
         flash_read_enable <= 1'b0;
         page_index        <= 4'd0;
         flash_byte_addr   <= '0;
         lat_size          <= FLASH_RD_SIZE_1;
         lat_addr          <= '0;
         byte_idx          <= 2'd0;
         // NOTE: the accumulator is a plain register, not a memory, so it is
         // reset with everything else; a late byte can never leak into a
         // response after reset.
         acc               <= 32'd0;
         to_cnt            <= 16'd0;
         advance           <= 1'b0;
         timed_out         <= 1'b0;
      end else begin
         // One-cycle strobes default low.
         flash_read_enable <= 1'b0;
         rsp_valid         <= 1'b0;

         case (state)
            S_IDLE: begin
               if (loader_done) begin
                  req_ready <= 1'b1;
                  state     <= S_READY;
               end
            end

            S_READY: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  lat_addr  <= req_addr;
                  lat_size  <= flash_rd_size_e'(req_size);
                  byte_idx  <= 2'd0;
                  acc       <= 32'd0;
                  timed_out <= 1'b0;
                  advance   <= 1'b0;
                  if (req_size == FLASH_RD_SIZE_ILLEGAL) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= 32'd0;
                     rsp_error <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     // Byte 0 is launched straight from the handshake so its
                     // pulse is visible in the S_ISSUE cycle right after.
                     page_index        <= req_page;
                     flash_byte_addr   <= req_addr;
                     flash_read_enable <= 1'b1;
                     state             <= S_ISSUE;
                  end
               end
            end

            // Pulse cycle: the loader sees flash_read_enable now.
            S_ISSUE: begin
               to_cnt <= 16'd0;
               state  <= S_WAIT;
            end

            S_WAIT: begin
               if (advance) begin
                  // Address wraps inside the code RAM; the page is fixed.
                  advance           <= 1'b0;
                  flash_byte_addr   <= lat_addr + ADDR_WIDTH'(byte_idx);
                  flash_read_enable <= 1'b1;
                  state             <= S_ISSUE;
               end else if (flash_read_en_out) begin
                  acc <= merged;
                  if (byte_idx == last_byte_index(lat_size)) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= merged;
                     rsp_error <= 1'b0;
                     state     <= S_RESP;
                  end else begin
                     byte_idx <= byte_idx + 2'd1;
                     advance  <= 1'b1;
                  end
               end else if (to_cnt >= TIMEOUT_LAST) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= acc;
                  rsp_error <= 1'b1;
                  timed_out <= 1'b1;
                  state     <= S_RESP;
               end else if (to_cnt != 16'hFFFF) begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end

            S_RESP: begin
               if (timed_out) begin
                  state <= S_FAULT;
               end else begin
                  req_ready <= 1'b1;
                  state     <= S_READY;
               end
            end

            // Sticky: the loader may still answer the abandoned read.
            S_FAULT: begin
               state <= S_FAULT;
            end

            default: begin
               req_ready <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_code_mem_flash_reader.sv
// -----------------------------------------------------------------------------
// tb_code_mem_flash_reader
//
// Bench for code_mem_flash_reader with a behavioural single-byte loader of
// programmable latency. Expected issue addresses and responses are queued when
// each request is driven and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_code_mem_flash_reader;

   localparam int AW = 15;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          sync_reset;
   logic          loader_done;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_page;
   logic [AW-1:0] req_addr;
   logic [1:0]    req_size;
   logic          rsp_valid;
   logic [31:0]   rsp_data;
   logic          rsp_error;
   logic          flash_read_enable;
   logic [3:0]    page_index;
   logic [AW-1:0] flash_byte_addr;
   logic          flash_read_en_out;
   logic [7:0]    flash_byte_out;

   code_mem_flash_reader #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk               (clk),
      .sync_reset        (sync_reset),
      .loader_done       (loader_done),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_page          (req_page),
      .req_addr          (req_addr),
      .req_size          (req_size),
      .rsp_valid         (rsp_valid),
      .rsp_data          (rsp_data),
      .rsp_error         (rsp_error),
      .flash_read_enable (flash_read_enable),
      .page_index        (page_index),
      .flash_byte_addr   (flash_byte_addr),
      .flash_read_en_out (flash_read_en_out),
      .flash_byte_out    (flash_byte_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          tol;
      logic        rdy_after;
   } rsp_t;

   rsp_t          rsp_q[$];
   logic [18:0]   addr_q[$];   // {page, byte address}
   logic [7:0]    byte_q[$];
   int            hs_cyc   = 0;
   int            rsp_cnt  = 0;
   int            lat_l    = 4;
   bit            mute     = 1'b0;
   bit            pending  = 1'b0;
   int            pend_cyc = 0;
   bit            chk_rdy  = 1'b0;
   logic          exp_rdy  = 1'b0;

   // Loader model: one byte strobe lat_l cycles after each read pulse.
   initial begin
      flash_read_en_out = 1'b0;
      flash_byte_out    = 8'h00;
      forever begin
         @(negedge clk);
         flash_read_en_out = 1'b0;
         if (pending && cyc == pend_cyc) begin
            pending = 1'b0;
            if (!mute && byte_q.size() > 0) begin
               flash_read_en_out = 1'b1;
               flash_byte_out    = byte_q.pop_front();
            end
         end
         if (flash_read_enable) begin
            if (pending) check("one_outstanding", 32'd1, 32'd0);
            if (addr_q.size() == 0) check("unexpected_issue", 32'd1, 32'd0);
            else check("issue_addr", 32'({page_index, flash_byte_addr}), 32'(addr_q.pop_front()));
            pending  = 1'b1;
            pend_cyc = cyc + lat_l;
         end
      end
   end

   // Response monitor.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (chk_rdy) begin
            check("ready_after_rsp", 32'(req_ready), 32'(exp_rdy));
            chk_rdy = 1'b0;
         end
         if (!sync_reset) check("ready_inflight", 32'(req_ready & pending), 32'd0);
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               check("rsp_data", rsp_data, r.data);
               check("rsp_error", 32'(rsp_error), 32'(r.err));
               if (r.tol == 0)
                  check("rsp_latency", 32'(cyc - hs_cyc), 32'(r.lat));
               else
                  check("rsp_latency_window",
                        32'((cyc - hs_cyc >= r.lat) && (cyc - hs_cyc <= r.lat + r.tol)), 32'd1);
               exp_rdy = r.rdy_after;
               chk_rdy = 1'b1;
               rsp_cnt++;
            end
         end
      end
   end

   // Drive one request; handshake cycle is cycle 0 for the latency check.
   task automatic drive_req(input logic [3:0] page, input logic [AW-1:0] addr,
                            input logic [1:0] size, output bit ok);
      int t;
      @(negedge clk);
      req_valid = 1'b1;
      req_page  = page;
      req_addr  = addr;
      req_size  = size;
      t = 0;
      while (!req_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      ok = req_ready;
      if (!ok) check("handshake_timeout", 32'd0, 32'd1);
      hs_cyc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_req(input logic [3:0] page, input logic [AW-1:0] addr,
                         input logic [1:0] size, input logic [31:0] exp_data,
                         input logic exp_err, input int lat, input int tol,
                         input int n_issue, input logic rdy_after);
      logic [AW-1:0] a;
      int start;
      int t;
      bit ok;
      for (int i = 0; i < n_issue; i++) begin
         a = addr + AW'(i);
         addr_q.push_back({page, a});
      end
      rsp_q.push_back('{exp_data, exp_err, lat, tol, rdy_after});
      start = rsp_cnt;
      drive_req(page, addr, size, ok);
      if (!ok) return;
      t = 0;
      while (rsp_cnt == start && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (rsp_cnt == start) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, 32'({req_ready, rsp_valid, rsp_error, flash_read_enable,
                      page_index, flash_byte_addr}), 32'd0);
      check({tag, "_data"}, rsp_data, 32'd0);
   endtask

   initial begin
      bit ok;
      int hi;
      int t;

      sync_reset  = 1'b1;
      loader_done = 1'b0;
      req_valid   = 1'b1;
      req_page    = 4'h0;
      req_addr    = '0;
      req_size    = 2'd0;

      // Reset held with a request pending: nothing happens.
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      sync_reset = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_no_ready", 32'({req_ready, flash_read_enable}), 32'd0);
      req_valid   = 1'b0;
      loader_done = 1'b1;

      // Word read, L = 4: 1 + 16 + 6 + 1 = 24.
      lat_l = 4;
      byte_q.push_back(8'h11); byte_q.push_back(8'h22);
      byte_q.push_back(8'h33); byte_q.push_back(8'h44);
      do_req(4'd2, 15'h0100, 2'd2, 32'h4433_2211, 1'b0, 24, 0, 4, 1'b1);

      // Half-word wrapping past the top of the code RAM: 1 + 8 + 2 + 1 = 12.
      byte_q.push_back(8'hAB); byte_q.push_back(8'hCD);
      do_req(4'd5, 15'h7FFF, 2'd1, 32'h0000_CDAB, 1'b0, 12, 0, 2, 1'b1);

      // Illegal size: error response one cycle after handshake, no access.
      do_req(4'd7, 15'h1234, 2'd3, 32'h0, 1'b1, 1, 0, 0, 1'b1);

      // Single byte with L = 1: 1 + 1 + 1 = 3.
      lat_l = 1;
      byte_q.push_back(8'h77);
      do_req(4'd9, 15'h0042, 2'd0, 32'h0000_0077, 1'b0, 3, 0, 1, 1'b1);

      // Reset while waiting on the loader; its late strobe must be dropped.
      lat_l = 6;
      addr_q.push_back({4'd1, 15'h0010});
      byte_q.push_back(8'h99);
      drive_req(4'd1, 15'h0010, 2'd0, ok);
      @(negedge clk);
      sync_reset  = 1'b1;
      loader_done = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs_zero("mid_reset");
      sync_reset = 1'b0;
      repeat (12) @(negedge clk);
      check("late_strobe_sent", 32'(byte_q.size()), 32'd0);
      check("idle_after_reset", 32'({req_ready, rsp_valid}), 32'd0);
      loader_done = 1'b1;
      lat_l = 4;
      byte_q.push_back(8'h5A);
      do_req(4'd1, 15'h0010, 2'd0, 32'h0000_005A, 1'b0, 6, 0, 1, 1'b1);

      // Timeout: loader never answers a 2-byte read.
      mute = 1'b1;
      do_req(4'd3, 15'h0200, 2'd1, 32'h0, 1'b1, 9, 1, 1, 1'b0);
      hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (req_ready) hi++;
      end
      check("fault_sticky", 32'(hi), 32'd0);

      // Only reset leaves the fault state.
      sync_reset = 1'b1;
      repeat (2) @(negedge clk);
      sync_reset = 1'b0;
      mute       = 1'b0;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready_after_fault_reset", 32'(req_ready), 32'd1);
      lat_l = 2;
      byte_q.push_back(8'hC3);
      do_req(4'hF, 15'h7FFE, 2'd0, 32'h0000_00C3, 1'b0, 4, 0, 1, 1'b1);

      repeat (5) @(negedge clk);
      check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
      check("addr_queue_empty", 32'(addr_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/code_mem_flash_reader.md
# code_mem_flash_reader

Multi-byte read front-end for the code-memory loader's post-boot flash byte port. It accepts 1-, 2- or 4-byte little-endian read requests from the MCU side with a ready/valid handshake. It drives the loader's single-byte read interface, issuing exactly one byte read at a time, assembles the bytes, and returns one response. It sits directly downstream of the loader and upstream of the MCU SFR/data bus glue.

## Interface
- `ADDR_WIDTH`, default 15: byte-address width, equal to `$clog2(ON_CHIP_CODE_RAM_SIZE_IN_BYTES)`.
- `TIMEOUT_CYCLES`, default 255: maximum cycles allowed per byte before a fault; legal range 1..65535.
- `clk`  in  1  clock; one clock domain, all logic on its rising edge.
- `sync_reset`  in  1  reset; **synchronous, active-high**.
- `loader_done`  in  1  loader has finished power-on copy; its byte port is usable.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when high together with `req_valid`.
- `req_page`  in  4  flash page index.
- `req_addr`  in  ADDR_WIDTH  start byte address.
- `req_size`  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = illegal.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_data`  out  32  assembled data; byte i in [8i+7:8i]; unused upper bytes are 0.
- `rsp_error`  out  1  qualifies `rsp_valid`: illegal size or timeout.
- `flash_read_enable`  out  1  one-cycle byte-read pulse to the loader.
- `page_index`  out  4  page to the loader.
- `flash_byte_addr`  out  ADDR_WIDTH  byte address to the loader.
- `flash_read_en_out`  in  1  loader byte-valid strobe.
- `flash_byte_out`  in  8  loader byte data.

## Operation
- All outputs are registered. Reset value of every output and internal register is 0; the FSM resets to S_IDLE.
- FSM states: S_IDLE, S_READY, S_ISSUE, S_WAIT, S_RESP, S_FAULT.
- S_IDLE: `req_ready` = 0. Go to S_READY once `loader_done` = 1.
- S_READY: `req_ready` = 1. On handshake:
  - Latch page, address and size; clear byte index and the data accumulator.
  - If size = 3, go to S_RESP with the error flag set.
  - Otherwise go to S_ISSUE.
- S_ISSUE:
  - Drive `page_index` and `flash_byte_addr` = latched address + byte index. The sum wraps modulo 2^ADDR_WIDTH; the page does not change.
  - Pulse `flash_read_enable` for one cycle.
  - Clear the timeout counter and go to S_WAIT.
- S_WAIT:
  - `flash_byte_addr` and `page_index` stay constant; the loader relatches the address while it is done.
  - No further `flash_read_enable` is issued, so at most one byte is outstanding.
  - On `flash_read_en_out`, write `flash_byte_out` into byte lane [index].
  - If that was the last byte (index = 2^size − 1), go to S_RESP; otherwise increment the index and go to S_ISSUE.
  - A strobe in any other state is ignored.
- S_WAIT timeout: if the counter reaches TIMEOUT_CYCLES with no strobe, go to S_RESP with the error flag set, and S_FAULT follows.
- S_RESP:
  - `rsp_valid` = 1 for one cycle. `rsp_data` = accumulator: lanes filled so far, others 0. `rsp_error` = error flag.
  - Next state is S_READY, or S_FAULT after a timeout.
- S_FAULT: `req_ready` = 0. Sticky until `sync_reset`, because the loader may still hold an outstanding read.
- `loader_done` falling in any state has no effect; the loader never deasserts it.
- `rsp_data` and `rsp_error` hold their values between responses. Only `rsp_valid` qualifies them.
- Reset mid-transaction: return to S_IDLE immediately with all outputs 0. A late `flash_read_en_out` is discarded.

## Timing
- Handshake in cycle 0 → `flash_read_enable` is high in cycle 1.
- Byte strobe in cycle k → the next `flash_read_enable` is in cycle k+2 (S_ISSUE), or `rsp_valid` is in cycle k+1 (final byte).
- With loader latency L cycles per byte (pulse to strobe), an N-byte response arrives at cycle 1 + N·L + 2(N−1) + 1.
- Illegal size → `rsp_valid` with `rsp_error` = 1 in cycle 1. No flash access is made.
- `req_ready` is low from the cycle after acceptance until the cycle after `rsp_valid`. It is never high while a read is in flight.
- Back-to-back: after `rsp_valid` in cycle r, `req_ready` = 1 in cycle r+1.

## Structure
- Shared package `code_mem_pkg`:
  - size enum `FLASH_RD_SIZE_1/2/4/ILLEGAL` (2-bit);
  - localparam `CODE_MEM_ADDR_WIDTH` derived from `ON_CHIP_CODE_RAM_SIZE_IN_BYTES`;
  - the FSM state enum.
- Single module. The timeout counter (16-bit, saturating) and the byte-lane accumulator are inline. No sub-module is warranted.

## Test plan
- Reset held, `loader_done` = 0, `req_valid` = 1 → `req_ready` = 0, no `flash_read_enable`; all outputs 0.
- Word read: page 2, addr 0x0100, size 2; loader model with L = 4 returns 0x11, 0x22, 0x33, 0x44 → addresses 0x0100..0x0103 issued one at a time; `rsp_data` = 0x44332211, `rsp_error` = 0, `rsp_valid` in cycle 1 + 16 + 6 + 1 = 24.
- Wrap: addr 0x7FFF, size 1, bytes 0xAB, 0xCD → second address 0x0000 on the same page; `rsp_data` = 0x0000CDAB.
- Illegal size 3 → `rsp_valid` with `rsp_error` = 1 in cycle 1, `rsp_data` = 0, no `flash_read_enable`.
- Timeout: TIMEOUT_CYCLES = 8, loader never strobes on a 2-byte read → `rsp_error` = 1 after 8 wait cycles, `rsp_data` = 0; `req_ready` stays 0 until `sync_reset`.
- Reset asserted in S_WAIT, then a strobe arrives → strobe ignored; after `loader_done`, a 1-byte read of 0x5A returns 0x0000005A.
